// File: rtl/romulus_pdo_serializer.sv
// Output stage of the Romulus datapath: serializes a captured 128-bit pdo block MSB-first into
// outwidth-bit words, or checks a tag block against an expected-tag stream and reports pass/fail.
module romulus_pdo_serializer #(
    parameter int outwidth = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [127:0]        blk_i,
    input  logic [4:0]          blk_len,
    input  logic                blk_tag,
    input  logic                verify,
    input  logic                blk_load,
    output logic                blk_ready,
    output logic [outwidth-1:0] do_data,
    output logic                do_valid,
    output logic                do_last,
    input  logic                do_ready,
    input  logic [outwidth-1:0] exp_data,
    input  logic                exp_valid,
    output logic                exp_ready,
    output logic                tag_done,
    output logic                tag_ok,
    output logic [1:0]          dbg_state
);
    localparam int BPW = outwidth / 8;
    localparam logic [5:0] BPW6    = 6'(BPW);
    localparam logic [5:0] BPW6_M1 = 6'(BPW - 1);

    typedef enum logic [1:0] {IDLE, SEND, CHECK, RESULT} state_t;

    // Handshakes: a word moves on do_data when do_valid & do_ready are both high at posedge; an
    // expected-tag word is consumed when exp_valid & exp_ready are both high at posedge. A block is
    // captured when blk_load & blk_ready are both high at posedge. Valid outputs never depend on ready.
    state_t                state, state_nx;
    logic [127:0]          blk_r;
    logic [4:0]            len_r, nwords_r, idx_r;
    logic                  mismatch_r, tag_ok_r;
    logic [4:0]            len_in, nwords_in;
    logic [127:0]          shifted;
    logic [outwidth-1:0]   word, mask, word_m;
    logic                  last_word, exp_mis;

    assign len_in    = (blk_len > 5'd16) ? 5'd16 : blk_len;
    assign nwords_in = 5'((6'(len_in) + BPW6_M1) / BPW6);

    assign shifted   = blk_r << (idx_r * outwidth);
    assign word      = shifted[127 -: outwidth];
    assign last_word = (idx_r == nwords_r - 5'd1);

    // Byte lanes at or beyond the block length are masked out of both output and comparison.
    always_comb begin
        mask = '0;
        for (int j = 0; j < BPW; j++) begin
            if ((int'(idx_r) * BPW + j) < int'(len_r))
                mask[outwidth-1-8*j -: 8] = 8'hFF;
        end
    end

    assign word_m  = word & mask;
    assign exp_mis = |((exp_data ^ word) & mask);

    always_comb begin
        state_nx  = state;
        blk_ready = 1'b0;
        do_valid  = 1'b0;
        do_last   = 1'b0;
        do_data   = '0;
        exp_ready = 1'b0;
        tag_done  = 1'b0;
        case (state)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_load) begin
                    if (blk_tag && verify)   state_nx = CHECK;
                    else if (len_in != 5'd0) state_nx = SEND;
                end
            end
            SEND: begin
                do_valid = 1'b1;
                do_data  = word_m;
                do_last  = last_word;
                if (do_ready && last_word) state_nx = IDLE;
            end
            CHECK: begin
                if (len_r == 5'd0) begin
                    state_nx = RESULT;
                end else begin
                    exp_ready = 1'b1;
                    if (exp_valid && last_word) state_nx = RESULT;
                end
            end
            RESULT: begin
                tag_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Reset silences every output in the same cycle it is raised.
        if (rst) begin
            blk_ready = 1'b0;
            do_valid  = 1'b0;
            do_last   = 1'b0;
            do_data   = '0;
            exp_ready = 1'b0;
            tag_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            blk_r      <= '0;
            len_r      <= '0;
            nwords_r   <= '0;
            idx_r      <= '0;
            mismatch_r <= 1'b0;
            tag_ok_r   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (blk_load) begin
                        blk_r    <= blk_i;
                        len_r    <= len_in;
                        nwords_r <= nwords_in;
                        idx_r    <= '0;
                        if (blk_tag && verify) begin
                            mismatch_r <= 1'b0;
                            tag_ok_r   <= 1'b0;
                        end
                    end
                end
                SEND: begin
                    if (do_ready && !last_word) idx_r <= idx_r + 5'd1;
                end
                CHECK: begin
                    if (len_r == 5'd0) begin
                        tag_ok_r <= 1'b1;
                    end else if (exp_valid) begin
                        mismatch_r <= mismatch_r | exp_mis;
                        idx_r      <= idx_r + 5'd1;
                        // Result is registered as RESULT is entered so it is valid with tag_done.
                        if (last_word) tag_ok_r <= !(mismatch_r | exp_mis);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tag_ok    = tag_ok_r & !rst;
    assign dbg_state = state;
endmodule

// File: tb/tb_romulus_pdo_serializer.sv
// Bench for romulus_pdo_serializer (outwidth=32): vector table, randomized blocks checked against a
// byte-level reference model, and hand sequences for reset abort and ignored loads.
module tb_romulus_pdo_serializer;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] blk_i;
    logic [4:0]   blk_len;
    logic         blk_tag, verify, blk_load, blk_ready;
    logic [31:0]  do_data;
    logic         do_valid, do_last, do_ready;
    logic [31:0]  exp_data;
    logic         exp_valid, exp_ready, tag_done, tag_ok;
    logic [1:0]   dbg_state;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    localparam logic [127:0] K = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    romulus_pdo_serializer #(.outwidth(32)) dut (
        .clk(clk), .rst(rst), .blk_i(blk_i), .blk_len(blk_len), .blk_tag(blk_tag),
        .verify(verify), .blk_load(blk_load), .blk_ready(blk_ready), .do_data(do_data),
        .do_valid(do_valid), .do_last(do_last), .do_ready(do_ready), .exp_data(exp_data),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .tag_done(tag_done), .tag_ok(tag_ok),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the block as a byte string, byte 0 first; bytes beyond len read as zero.
    function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
        byte_of = b[127-8*i -: 8];
    endfunction

    function automatic logic [31:0] model_word(input logic [127:0] b, input int k, input int len);
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++)
            w = {w[23:0], ((4*k + j) < len) ? byte_of(b, 4*k + j) : 8'h00};
        return w;
    endfunction

    function automatic bit model_tag_ok(input logic [127:0] b, input logic [127:0] e, input int len);
        for (int i = 0; i < len; i++)
            if (byte_of(b, i) != byte_of(e, i)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_block(input logic [127:0] b, input int len, input bit tag, input bit ver,
                             input logic [127:0] eb, input int mode, input bit exp_ok);
        int eff, nw, k, cyc;
        bit done, held;
        logic [31:0] held_data;
        logic        held_last;
        eff = (len > 16) ? 16 : len;
        nw  = (eff * 8 + 31) / 32;
        for (int i = 0; i < 20 && !blk_ready; i++) step();
        check("blk_ready_before_load", blk_ready, 1'b1);
        blk_i = b; blk_len = 5'(len); blk_tag = tag; verify = ver; blk_load = 1'b1;
        step();
        blk_load = 1'b0;
        if (tag && ver) begin
            k = 0; done = 1'b0;
            for (cyc = 0; cyc < 100 && !done; cyc++) begin
                exp_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                exp_data  = model_word(eb, (k < 4) ? k : 3, 16);
                if (do_valid) check("no_do_valid_in_check", do_valid, 1'b0);
                if (tag_done) begin
                    check("tag_ok", tag_ok, exp_ok);
                    check("exp_words_consumed", k, nw);
                    done = 1'b1;
                end else begin
                    if (exp_valid && exp_ready) k++;
                    step();
                end
            end
            exp_valid = 1'b0;
            check("tag_done_seen", done, 1'b1);
            step();
            check("tag_done_one_cycle", tag_done, 1'b0);
            check("tag_ok_held", tag_ok, exp_ok);
        end else if (nw == 0) begin
            for (int i = 0; i < 3; i++) begin
                check("dropped_no_valid", do_valid, 1'b0);
                check("dropped_ready", blk_ready, 1'b1);
                step();
            end
        end else begin
            for (int i = 0; i < nw; i++) exp_q.push_back(model_word(b, i, eff));
            done = 1'b0; held = 1'b0; held_data = '0; held_last = 1'b0;
            for (cyc = 0; cyc < 200 && !done; cyc++) begin
                do_ready = ready_for(mode, cyc);
                if (held) begin
                    check("stall_valid", do_valid, 1'b1);
                    check("stall_data", do_data, held_data);
                    check("stall_last", do_last, held_last);
                end
                held = 1'b0;
                if (do_valid && exp_q.size() > 0) begin
                    if (do_ready) begin
                        check("word", do_data, exp_q.pop_front());
                        check("do_last", do_last, exp_q.size() == 0);
                        done = (exp_q.size() == 0);
                    end else begin
                        held = 1'b1; held_data = do_data; held_last = do_last;
                    end
                end else if (do_valid) begin
                    check("extra_word", do_valid, 1'b0);
                    done = 1'b1;
                end
                step();
            end
            do_ready = 1'b0;
            check("all_words_seen", done, 1'b1);
            check("idle_after_last_valid", do_valid, 1'b0);
            check("ready_after_last", blk_ready, 1'b1);
            exp_q.delete();
        end
    endtask

    typedef struct {
        logic [127:0] blk;
        int           len;
        bit           tag;
        bit           ver;
        logic [127:0] expblk;
        int           mode;
        bit           exp_ok;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [127:0] rb, re;
        int rl, hs;
        rst = 1'b1; blk_i = '0; blk_len = '0; blk_tag = 1'b0; verify = 1'b0; blk_load = 1'b0;
        do_ready = 1'b0; exp_data = '0; exp_valid = 1'b0;

        vecs[0]  = '{K, 16, 0, 0, K, 0, 1};
        vecs[1]  = '{K, 6,  0, 0, K, 0, 1};
        vecs[2]  = '{K, 16, 0, 0, K, 1, 1};
        vecs[3]  = '{K, 16, 1, 1, K, 0, 1};
        vecs[4]  = '{K, 16, 1, 1, 128'h00112233_44556677_8899AABA_CCDDEEFF, 0, 0};
        vecs[5]  = '{K, 0,  1, 1, K, 0, 1};
        vecs[6]  = '{K, 5,  1, 1, 128'h00112233_44FF6677_8899AABB_CCDDEEFF, 0, 1};
        vecs[7]  = '{K, 5,  1, 1, 128'h001122FF_44556677_8899AABB_CCDDEEFF, 0, 0};
        vecs[8]  = '{K, 0,  0, 0, K, 0, 1};
        vecs[9]  = '{K, 13, 1, 0, K, 2, 1};
        vecs[10] = '{K, 20, 0, 0, K, 0, 1};

        step();
        check("rst_blk_ready", blk_ready, 1'b0);
        check("rst_do_valid", do_valid, 1'b0);
        check("rst_do_data", do_data, 32'h0);
        check("rst_exp_ready", exp_ready, 1'b0);
        check("rst_tag_done", tag_done, 1'b0);
        check("rst_tag_ok", tag_ok, 1'b0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_blk_ready", blk_ready, 1'b1);
        check("post_rst_do_last", do_last, 1'b0);

        for (int i = 0; i < 11; i++)
            run_block(vecs[i].blk, vecs[i].len, vecs[i].tag, vecs[i].ver,
                      vecs[i].expblk, vecs[i].mode, vecs[i].exp_ok);

        for (int i = 0; i < 25; i++) begin
            rb = {$urandom, $urandom, $urandom, $urandom};
            re = rb;
            if ($urandom_range(0, 1)) re[8*$urandom_range(0, 15) +: 8] ^= 8'h5A;
            rl = $urandom_range(0, 16);
            if ($urandom_range(0, 1))
                run_block(rb, rl, 1, 1, re, 2, model_tag_ok(rb, re, rl));
            else
                run_block(rb, rl, $urandom_range(0, 1), 0, rb, 2, 1);
        end

        // Load attempted mid-SEND must be ignored: words still come from the first block.
        blk_i = K; blk_len = 5'd16; blk_tag = 1'b0; verify = 1'b0; blk_load = 1'b1; do_ready = 1'b0;
        step();
        blk_load = 1'b1; blk_i = ~K; blk_len = 5'd4;
        check("busy_not_ready", blk_ready, 1'b0);
        step();
        blk_load = 1'b0;
        hs = 0;
        for (int c = 0; c < 20 && hs < 2; c++) begin
            do_ready = 1'b1;
            if (do_valid) begin
                check("ignored_load_word", do_data, model_word(K, hs, 16));
                hs++;
            end
            step();
        end
        // Reset after the second word: abort immediately, nothing more emitted.
        do_ready = 1'b1; rst = 1'b1;
        #1;
        check("abort_no_valid", do_valid, 1'b0);
        check("abort_blk_ready", blk_ready, 1'b0);
        step();
        check("abort_no_valid_2", do_valid, 1'b0);
        rst = 1'b0;
        step();
        check("abort_ready_after", blk_ready, 1'b1);
        check("abort_tag_ok", tag_ok, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("abort_quiet", do_valid, 1'b0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
